k_exp_inv: RTL and testbench

//  Decryption-side key schedule: produces AES round keys in reverse order (Nr..0) for the inverse cipher.

---
 rtl/k_exp_inv.sv | 210 +++++++++++++++++++++
 tb/tb_k_exp_inv.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/k_exp_inv.sv
// Inverse-cipher AES key schedule: expands forward to the tail of the schedule, then
// walks it backward one word per cycle, emitting round keys Nr..0 over a valid/ready port.
module k_exp_inv #(
  parameter bit ENABLE_192 = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [1:0]   key_len_i,
  input  logic [255:0] key_i,
  output logic         busy_o,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic         rk_last_o
);

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  state_t      state;
  logic [31:0] win [8];
  logic [5:0]  b;
  logic [3:0]  r;
  logic [3:0]  nk;
  logic [3:0]  nr;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic        len_ok;
  logic [3:0]  nk_sel;
  logic [3:0]  nr_sel;

  always_comb begin
    len_ok = 1'b1;
    nk_sel = 4'd4;
    nr_sel = 4'd10;
    case (key_len_i)
      2'b00: ;
      2'b01: begin
        nk_sel = 4'd6;
        nr_sel = 4'd12;
        len_ok = ENABLE_192;
      end
      2'b10: begin
        nk_sel = 4'd8;
        nr_sel = 4'd14;
      end
      default: len_ok = 1'b0;
    endcase
  end

  logic [2:0]   idx_hi;
  logic [2:0]   idx_hi2;
  logic [5:0]   j;
  logic [2:0]   jm;
  logic [3:0]   jq;
  logic [31:0]  t_in;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  t_out;
  logic [31:0]  w_new;
  logic [31:0]  w_prev;
  logic [5:0]   lim;
  logic         emit;
  logic [2:0]   off;
  logic [127:0] rk_sel;

  // One transform shared by both directions: forward uses (W[Nk-1], b+Nk), backward (W[Nk-2], b+Nk-1).
  always_comb begin
    idx_hi  = 3'(nk - 4'd1);
    idx_hi2 = 3'(nk - 4'd2);
    if (state == REV) begin
      t_in = win[idx_hi2];
      j    = b + {2'b00, nk} - 6'd1;
    end else begin
      t_in = win[idx_hi];
      j    = b + {2'b00, nk};
    end
    case (nk)
      4'd4: begin
        jm = {1'b0, j[1:0]};
        jq = j[5:2];
      end
      4'd8: begin
        jm = j[2:0];
        jq = {1'b0, j[5:3]};
      end
      default: begin
        jm = 3'(j % 6'd6);
        jq = 4'(j / 6'd6);
      end
    endcase
    sub_in  = (jm == 3'd0) ? {t_in[23:0], t_in[31:24]} : t_in;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (jm == 3'd0)
      t_out = sub_out ^ {rcon(jq), 24'h0};
    else if (nk == 4'd8 && jm == 3'd4)
      t_out = sub_out;
    else
      t_out = t_in;
    w_new  = win[0] ^ t_out;
    w_prev = win[idx_hi] ^ t_out;
    lim    = {nr, 2'b00} + 6'd4 - {2'b00, nk};
    emit   = ({r, 2'b00} >= b);
    off    = 3'({r, 2'b00} - b);
    rk_sel = {win[off], win[3'(off + 3'd1)], win[3'(off + 3'd2)], win[3'(off + 3'd3)]};
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < 8; i++) win[i] <= '0;
      b          <= '0;
      r          <= '0;
      nk         <= 4'd4;
      nr         <= 4'd10;
      rk_o       <= '0;
      rk_idx_o   <= '0;
      rk_valid_o <= 1'b0;
      rk_last_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && len_ok) begin
            for (int i = 0; i < 8; i++) win[i] <= key_i[255 - 32*i -: 32];
            b     <= '0;
            nk    <= nk_sel;
            nr    <= nr_sel;
            state <= FWD;
          end
        end
        FWD: begin
          for (int i = 0; i < 7; i++)
            if (3'(i) < idx_hi) win[i] <= win[i+1];
          win[idx_hi] <= w_new;
          b <= b + 6'd1;
          if (b + 6'd1 == lim) begin
            r     <= nr;
            state <= REV;
          end
        end
        REV: begin
          if (rk_valid_o && !rk_ready_i) begin
            // stalled: hold everything
          end else if (rk_valid_o && rk_last_o) begin
            rk_valid_o <= 1'b0;
            rk_last_o  <= 1'b0;
            state      <= IDLE;
          end else if (emit) begin
            rk_o       <= rk_sel;
            rk_idx_o   <= r;
            rk_valid_o <= 1'b1;
            rk_last_o  <= (r == 4'd0);
            if (r != 4'd0) r <= r - 4'd1;
          end else begin
            for (int i = 1; i < 8; i++) win[i] <= win[i-1];
            win[0]     <= w_prev;
            b          <= b - 6'd1;
            rk_valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k_exp_inv.sv
// Bench for k_exp_inv: FIPS-197 style forward expansion as reference, randomized keys,
// backpressure and control-input noise.
module tb_k_exp_inv;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   key_len_i = 2'b00;
  logic [255:0] key_i = '0;
  logic         busy_o;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx_o;
  logic         rk_valid_o;
  logic         rk_ready_i = 1'b0;
  logic         rk_last_o;

  always #5 clk = ~clk;

  k_exp_inv #(.ENABLE_192(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .key_len_i  (key_len_i),
    .key_i      (key_i),
    .busy_o     (busy_o),
    .rk_o       (rk_o),
    .rk_idx_o   (rk_idx_o),
    .rk_valid_o (rk_valid_o),
    .rk_ready_i (rk_ready_i),
    .rk_last_o  (rk_last_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   sb [256];
  logic [31:0]  wm [60];
  logic [127:0] got_rk [15];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // S-box from the generator-3 walk over GF(2^8), independent of how the design computes it.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [7:0] rc(input int n);
    logic [7:0] v;
    v = 8'h01;
    for (int k = 1; k < n; k++) v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    return v;
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) wm[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = wm[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc(i / nk), 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      wm[i] = wm[i-nk] ^ t;
    end
  endtask

  task automatic run_key(input logic [255:0] key, input logic [1:0] len, input bit rand_ready,
                         input bit poke, input string name);
    int nk, nr, lim, c, next_r, n_keys, first_c, second_c;
    bit done, held_v;
    logic [127:0] held_rk, exp_rk;
    logic [3:0] held_idx;
    nk = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
    nr = nk + 6;
    lim = 4*(nr+1) - nk;
    expand(key, nk, nr);
    for (int i = 0; i < 15; i++) got_rk[i] = '0;
    key_i = key;
    key_len_i = len;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check({name, "/busy_start"}, 128'(busy_o), 128'(1));
    c = 0; next_r = nr; n_keys = 0; first_c = -1; second_c = -1;
    done = 1'b0; held_v = 1'b0; held_rk = '0; held_idx = '0;
    while (!done && c < 1000) begin
      key_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      key_len_i = 2'($urandom_range(0, 3));
      start_i = (poke && c == lim + 3);
      if (held_v) begin
        check({name, "/stall_rk"}, rk_o, held_rk);
        check({name, "/stall_idx"}, 128'(rk_idx_o), 128'(held_idx));
        check({name, "/stall_vld"}, 128'(rk_valid_o), 128'(1));
        held_v = 1'b0;
      end
      rk_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_valid_o) begin
        if (first_c < 0) first_c = c;
        else if (second_c < 0 && rk_idx_o != 4'(nr)) second_c = c;
        if (rk_ready_i) begin
          exp_rk = {wm[4*next_r], wm[4*next_r+1], wm[4*next_r+2], wm[4*next_r+3]};
          check({name, "/idx"}, 128'(rk_idx_o), 128'(next_r));
          check({name, "/rk"}, rk_o, exp_rk);
          check({name, "/last"}, 128'(rk_last_o), 128'(next_r == 0));
          if (next_r >= 0 && next_r < 15) got_rk[next_r] = rk_o;
          n_keys++;
          if (next_r == 0) done = 1'b1;
          next_r--;
        end else begin
          held_v = 1'b1;
          held_rk = rk_o;
          held_idx = rk_idx_o;
        end
      end
      step();
      c++;
    end
    start_i = 1'b0;
    rk_ready_i = 1'b0;
    check({name, "/completed"}, 128'(done), 128'(1));
    check({name, "/n_keys"}, 128'(n_keys), 128'(nr + 1));
    check({name, "/busy_end"}, 128'(busy_o), 128'(0));
    check({name, "/vld_end"}, 128'(rk_valid_o), 128'(0));
    check({name, "/last_end"}, 128'(rk_last_o), 128'(0));
    if (!rand_ready) begin
      check({name, "/lat_first"}, 128'(first_c), 128'((nk == 4) ? 41 : (nk == 6) ? 47 : 53));
      check({name, "/lat_second"}, 128'(second_c), 128'((nk == 4) ? 46 : (nk == 6) ? 50 : 54));
    end
  endtask

  logic [255:0] k128, k192, k256, rkey;
  logic [1:0]   rlen;

  initial begin
    build_sbox();
    k128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
    k256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

    rst_n = 1'b0;
    step();
    step();
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_vld", 128'(rk_valid_o), 128'(0));
    check("rst_last", 128'(rk_last_o), 128'(0));
    check("rst_rk", rk_o, 128'(0));
    check("rst_idx", 128'(rk_idx_o), 128'(0));
    rst_n = 1'b1;
    step();

    run_key(k128, 2'b00, 1'b0, 1'b0, "aes128");
    check("aes128_rk10", got_rk[10], 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    check("aes128_rk0", got_rk[0], k128[255:128]);

    run_key(k192, 2'b01, 1'b0, 1'b0, "aes192");
    check("aes192_rk12", got_rk[12], 128'he98ba06f_448c773c_8ecc7204_01002202);
    check("aes192_rk0", got_rk[0], k192[255:128]);

    run_key(k256, 2'b10, 1'b0, 1'b0, "aes256");
    check("aes256_rk14", got_rk[14], 128'hfe4890d1_e6188d0b_046df344_706c631e);
    check("aes256_rk1", got_rk[1], 128'h1f352c07_3b6108d7_2d9810a3_0914dff4);

    // Reserved key length is ignored.
    key_len_i = 2'b11;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    check("reserved_len_busy", 128'(busy_o), 128'(0));
    check("reserved_len_vld", 128'(rk_valid_o), 128'(0));

    // Backpressure on the known vectors must reproduce the same sequences.
    run_key(k128, 2'b00, 1'b1, 1'b1, "aes128_bp");
    run_key(k256, 2'b10, 1'b1, 1'b0, "aes256_bp");

    // Reset in the middle of forward expansion, then a fresh run.
    key_i = k256;
    key_len_i = 2'b10;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    check("midrst_busy", 128'(busy_o), 128'(0));
    check("midrst_vld", 128'(rk_valid_o), 128'(0));
    check("midrst_last", 128'(rk_last_o), 128'(0));
    check("midrst_rk", rk_o, 128'(0));
    check("midrst_idx", 128'(rk_idx_o), 128'(0));
    rst_n = 1'b1;
    step();
    run_key(k192, 2'b01, 1'b0, 1'b0, "after_rst");

    for (int n = 0; n < 6; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rlen = 2'($urandom_range(0, 2));
      run_key(rkey, rlen, 1'b1, (n % 2) == 1, $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
